nonce_batch_ctrl: RTL and testbench

Parametrised nonce/time dispatcher feeding NUM_ENG hash engines in the mining core. It generalises the 3-engine nonce/time handling to N engines with explicit batches and per-engine masking of the final partial batch. Other additions are deferred time-tick application, found-engine priority encoding, and clean nonce-space exhaustion signalling. It sits between the header loader and the HashEngine array, and drives each engine's nonce word (header word 3) and the shared time word (header word 1).

---
 rtl/miner_pkg.sv | 21 ++
 rtl/prio_enc_lsb.sv | 22 ++
 rtl/nonce_batch_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_nonce_batch_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared types and helpers for the mining core: dispatcher state encoding,
// header byte-order conversion and the nonce-space ceiling.
package miner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FOUND,
        EXHAUST
    } nbc_state_t;

    localparam logic [31:0] NONCE_MAX = 32'hFFFF_FFFF;

    // Header words are kept in stored byte order; arithmetic happens on the
    // byte-reversed (numeric) view.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// asserted request plus a flag telling whether any request is asserted.
module prio_enc_lsb #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/nonce_batch_ctrl.sv
// Nonce/time dispatcher for NUM_ENG hash engines: issues nonce batches,
// collects completions, reports the winning engine or nonce-space exhaustion.
module nonce_batch_ctrl
    import miner_pkg::*;
#(
    parameter int NUM_ENG = 3,
    parameter int IDX_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1,
    parameter int TICK_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  job_load,
    input  logic [31:0]           job_time,
    input  logic [31:0]           job_nonce,
    input  logic                  sec_tick,
    input  logic [NUM_ENG-1:0]    eng_done,
    input  logic [NUM_ENG-1:0]    eng_found,
    output logic [NUM_ENG-1:0]    eng_start,
    output logic [NUM_ENG*32-1:0] eng_nonce,
    output logic [31:0]           hdr_time,
    output logic                  busy,
    output logic                  found_vld,
    output logic [IDX_W-1:0]      found_idx,
    output logic [31:0]           found_nonce,
    output logic [31:0]           found_time,
    output logic                  inc_vrn_flg
);

    nbc_state_t state_q, state_d;

    logic [32:0]        base_q;
    logic [31:0]        time_q;
    logic [TICK_W-1:0]  tick_q;
    logic [NUM_ENG-1:0] active_q;
    logic [NUM_ENG-1:0] done_q;
    logic [NUM_ENG-1:0] found_q;
    logic [31:0]        nonce_q [NUM_ENG];

    logic [32:0]        next_base;
    logic [32:0]        base_d;
    logic [31:0]        nonce_nxt [NUM_ENG];
    logic [NUM_ENG-1:0] active_nxt;
    logic [NUM_ENG-1:0] done_all;
    logic [NUM_ENG-1:0] found_all;
    logic               batch_done;
    logic               exhausted;
    logic               found_any;
    logic [IDX_W-1:0]   win_idx;
    logic [TICK_W-1:0]  tick_inc;
    logic [TICK_W-1:0]  tick_eff;

    logic start_wait;
    logic next_batch;
    logic go_found;
    logic go_exhaust;
    logic enter_issue;

    // Completion bookkeeping includes this cycle's pulses; inactive engines never count.
    assign done_all   = done_q | (eng_done & active_q);
    assign found_all  = found_q | (eng_done & eng_found & active_q);
    assign batch_done = (done_all == active_q);

    assign next_base  = base_q + 33'(NUM_ENG);
    assign exhausted  = (active_q != {NUM_ENG{1'b1}}) || (next_base > {1'b0, NONCE_MAX});

    assign tick_inc   = (&tick_q) ? tick_q : tick_q + 1'b1;
    assign tick_eff   = sec_tick ? tick_inc : tick_q;

    prio_enc_lsb #(
        .N (NUM_ENG),
        .W (IDX_W)
    ) u_found_enc (
        .req (found_all),
        .idx (win_idx),
        .any (found_any)
    );

    assign enter_issue = job_load | next_batch;
    assign base_d      = job_load ? {1'b0, bswap32(job_nonce)} : next_base;

    always_comb begin
        logic [32:0] cand;
        cand       = '0;
        active_nxt = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            cand          = base_d + 33'(i);
            nonce_nxt[i]  = bswap32(cand[31:0]);
            active_nxt[i] = (cand <= {1'b0, NONCE_MAX});
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        start_wait = 1'b0;
        next_batch = 1'b0;
        go_found   = 1'b0;
        go_exhaust = 1'b0;
        if (job_load) begin
            state_d = ISSUE;
        end else if (en) begin
            case (state_q)
                ISSUE: begin
                    state_d    = WAIT;
                    start_wait = 1'b1;
                end
                WAIT: begin
                    if (batch_done) begin
                        if (found_any) begin
                            state_d  = FOUND;
                            go_found = 1'b1;
                        end else if (exhausted) begin
                            state_d    = EXHAUST;
                            go_exhaust = 1'b1;
                        end else begin
                            state_d    = ISSUE;
                            next_batch = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: the nonce array is reset like any other register because it drives outputs that must read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= '0;
            time_q      <= '0;
            tick_q      <= '0;
            active_q    <= '0;
            done_q      <= '0;
            found_q     <= '0;
            found_vld   <= 1'b0;
            found_idx   <= '0;
            found_nonce <= '0;
            found_time  <= '0;
            inc_vrn_flg <= 1'b0;
            for (int i = 0; i < NUM_ENG; i++) nonce_q[i] <= '0;
        end else begin
            // Ticks seen up to the completing cycle are folded into the next batch's time.
            if (job_load) begin
                time_q <= bswap32(job_time);
                tick_q <= '0;
            end else if (next_batch) begin
                time_q <= time_q + 32'(tick_eff);
                tick_q <= '0;
            end else if (sec_tick && state_q != IDLE) begin
                tick_q <= tick_inc;
            end

            if (enter_issue) begin
                base_q   <= base_d;
                active_q <= active_nxt;
                for (int i = 0; i < NUM_ENG; i++) nonce_q[i] <= nonce_nxt[i];
            end

            if (job_load || start_wait) begin
                done_q  <= '0;
                found_q <= '0;
            end else if (state_q == WAIT) begin
                done_q  <= done_all;
                found_q <= found_all;
            end

            if (job_load) begin
                found_vld   <= 1'b0;
                found_idx   <= '0;
                found_nonce <= '0;
                found_time  <= '0;
                inc_vrn_flg <= 1'b0;
            end else begin
                if (go_found) begin
                    found_vld   <= 1'b1;
                    found_idx   <= win_idx;
                    found_nonce <= nonce_q[win_idx];
                    found_time  <= bswap32(time_q);
                end
                if (go_exhaust) inc_vrn_flg <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_ENG; g++) begin : g_nonce_out
        assign eng_nonce[g*32 +: 32] = nonce_q[g];
    end

    // A job_load in the issue cycle supersedes the batch, so it must not start engines.
    assign eng_start = (state_q == ISSUE && en && !job_load) ? active_q : '0;
    assign hdr_time  = bswap32(time_q);
    assign busy      = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_nonce_batch_ctrl.sv
// Self-checking bench for nonce_batch_ctrl: directed scenarios followed by
// randomized jobs checked against a numeric batch model.
module tb_nonce_batch_ctrl;

    localparam int N      = 3;
    localparam int IDX_W  = 2;
    localparam int TICK_W = 4;
    localparam int TICK_MAX = (1 << TICK_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             job_load = 1'b0;
    logic [31:0]      job_time = '0;
    logic [31:0]      job_nonce = '0;
    logic             sec_tick = 1'b0;
    logic [N-1:0]     eng_done = '0;
    logic [N-1:0]     eng_found = '0;
    logic [N-1:0]     eng_start;
    logic [N*32-1:0]  eng_nonce;
    logic [31:0]      hdr_time;
    logic             busy;
    logic             found_vld;
    logic [IDX_W-1:0] found_idx;
    logic [31:0]      found_nonce;
    logic [31:0]      found_time;
    logic             inc_vrn_flg;

    int checks = 0;
    int errors = 0;

    nonce_batch_ctrl #(.NUM_ENG(N), .IDX_W(IDX_W), .TICK_W(TICK_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .job_load    (job_load),
        .job_time    (job_time),
        .job_nonce   (job_nonce),
        .sec_tick    (sec_tick),
        .eng_done    (eng_done),
        .eng_found   (eng_found),
        .eng_start   (eng_start),
        .eng_nonce   (eng_nonce),
        .hdr_time    (hdr_time),
        .busy        (busy),
        .found_vld   (found_vld),
        .found_idx   (found_idx),
        .found_nonce (found_nonce),
        .found_time  (found_time),
        .inc_vrn_flg (inc_vrn_flg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
    endfunction

    function automatic logic [N*32-1:0] exp_nonces(input longint unsigned b);
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[i*32 +: 32] = swap_bytes(32'(b + longint'(i)));
        return v;
    endfunction

    function automatic logic [N-1:0] exp_active(input longint unsigned b);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (b + longint'(i)) <= 64'hFFFF_FFFF;
        return m;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: pulses default low, caller then drives this cycle's inputs.
    task automatic adv();
        @(posedge clk);
        #1;
        job_load  = 1'b0;
        sec_tick  = 1'b0;
        eng_done  = '0;
        eng_found = '0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, eng_start, 0);
        check({tag, "_nonce"}, eng_nonce, 0);
        check({tag, "_hdr"}, hdr_time, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fvld"}, found_vld, 0);
        check({tag, "_fidx"}, found_idx, 0);
        check({tag, "_fnonce"}, found_nonce, 0);
        check({tag, "_ftime"}, found_time, 0);
        check({tag, "_inc"}, inc_vrn_flg, 0);
    endtask

    // One random job driven through the numeric batch model.
    task automatic random_job();
        longint unsigned base;
        logic [31:0]     tmn;
        int              pending;
        int              max_b;
        int              batches;
        bit              finished;
        bit              tick_now;
        logic [N-1:0]    act;
        logic [N-1:0]    fmask;
        int              dly [N];
        int              maxd;
        int              idx;

        base  = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF - longint'($urandom_range(0, 12))
                                            : longint'($urandom);
        tmn   = $urandom;
        max_b = $urandom_range(1, 5);

        adv();
        job_load  = 1'b1;
        job_nonce = swap_bytes(32'(base));
        job_time  = swap_bytes(tmn);
        sec_tick  = ($urandom_range(0, 3) == 0);
        eng_done  = N'($urandom);
        eng_found = N'($urandom);
        mid();
        pending = 0;
        batches = 0;
        finished = 1'b0;

        // Issue cycle after the load; stray completions here lie outside any batch.
        adv();
        tick_now  = ($urandom_range(0, 3) == 0);
        sec_tick  = tick_now;
        eng_done  = N'($urandom);
        eng_found = N'($urandom);
        mid();

        while (!finished) begin
            act = exp_active(base);
            check("rnd_issue_start", eng_start, act);
            check("rnd_issue_nonce", eng_nonce, exp_nonces(base));
            check("rnd_issue_time", hdr_time, swap_bytes(tmn));
            check("rnd_issue_busy", busy, 1);
            if (tick_now) pending = (pending < TICK_MAX) ? pending + 1 : TICK_MAX;
            batches++;

            fmask = '0;
            maxd  = 0;
            for (int i = 0; i < N; i++) begin
                dly[i] = act[i] ? int'($urandom_range(1, 5)) : 0;
                if (act[i] && $urandom_range(0, 11) == 0) fmask[i] = 1'b1;
                if (dly[i] > maxd) maxd = dly[i];
            end

            if (batches == max_b) begin
                // Abandon: the next job_load lands before the last completion.
                for (int k = 1; k < maxd; k++) begin
                    adv();
                    for (int i = 0; i < N; i++) begin
                        eng_done[i]  = (dly[i] == k);
                        eng_found[i] = (dly[i] == k) && fmask[i];
                    end
                    mid();
                end
                finished = 1'b1;
            end else begin
                for (int k = 1; k <= maxd; k++) begin
                    adv();
                    tick_now = ($urandom_range(0, 3) == 0);
                    sec_tick = tick_now;
                    for (int i = 0; i < N; i++) begin
                        eng_done[i]  = (dly[i] == k) || (!act[i] && $urandom_range(0, 1) == 1);
                        eng_found[i] = (dly[i] == k) ? fmask[i] : ($urandom_range(0, 1) == 1);
                    end
                    mid();
                    check("rnd_wait_start", eng_start, 0);
                    if (tick_now) pending = (pending < TICK_MAX) ? pending + 1 : TICK_MAX;
                end

                adv();
                tick_now  = ($urandom_range(0, 3) == 0);
                sec_tick  = tick_now;
                eng_done  = N'($urandom);
                eng_found = N'($urandom);
                mid();

                if (fmask != 0) begin
                    idx = 0;
                    while (!fmask[idx]) idx++;
                    check("rnd_found_vld", found_vld, 1);
                    check("rnd_found_idx", found_idx, idx);
                    check("rnd_found_nonce", found_nonce, swap_bytes(32'(base + longint'(idx))));
                    check("rnd_found_time", found_time, swap_bytes(tmn));
                    check("rnd_found_busy", busy, 0);
                    finished = 1'b1;
                end else if (base + longint'(N) > 64'hFFFF_FFFF) begin
                    check("rnd_exh_flag", inc_vrn_flg, 1);
                    check("rnd_exh_busy", busy, 0);
                    check("rnd_exh_start", eng_start, 0);
                    finished = 1'b1;
                end else begin
                    base    = base + longint'(N);
                    tmn     = tmn + 32'(pending);
                    pending = 0;
                end
            end
        end
    endtask

    initial begin
        en = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // First batch right after the load.
        adv(); job_load = 1'b1; job_nonce = 32'h0000_0000; job_time = 32'h5E3A_0000; mid();
        adv(); mid();
        check("b1_start", eng_start, 3'b111);
        check("b1_nonce", eng_nonce, {32'h0200_0000, 32'h0100_0000, 32'h0000_0000});
        check("b1_time", hdr_time, 32'h5E3A_0000);
        check("b1_busy", busy, 1);
        adv(); eng_done = 3'b111; mid();
        adv(); mid();
        check("b2_start", eng_start, 3'b111);
        check("b2_nonce", eng_nonce, {32'h0500_0000, 32'h0400_0000, 32'h0300_0000});

        // Staggered completions with two finders; lowest index wins.
        adv(); mid();
        adv(); job_load = 1'b1; job_nonce = 32'h0000_0000; job_time = 32'h5E3A_0000; mid();
        adv(); mid();
        check("stg_start", eng_start, 3'b111);
        adv(); eng_done = 3'b001; mid();
        adv(); mid();
        adv(); eng_done = 3'b100; eng_found = 3'b110; mid();
        adv(); mid();
        adv(); eng_done = 3'b010; eng_found = 3'b010; mid();
        check("stg_not_yet", found_vld, 0);
        adv(); mid();
        check("stg_vld", found_vld, 1);
        check("stg_idx", found_idx, 1);
        check("stg_nonce", found_nonce, 32'h0100_0000);
        check("stg_time", found_time, 32'h5E3A_0000);
        check("stg_busy", busy, 0);
        repeat (3) begin
            adv(); eng_done = 3'b111; mid();
            check("stg_hold_start", eng_start, 0);
            check("stg_hold_vld", found_vld, 1);
        end

        // Partial final batch and exhaustion.
        adv(); job_load = 1'b1; job_nonce = 32'hFEFF_FFFF; job_time = 32'h1122_3344; mid();
        adv(); mid();
        check("exh_start", eng_start, 3'b011);
        check("exh_nonce", eng_nonce, {32'h0000_0000, 32'hFFFF_FFFF, 32'hFEFF_FFFF});
        check("exh_vld_cleared", found_vld, 0);
        adv(); eng_done = 3'b111; mid();
        adv(); mid();
        check("exh_flag", inc_vrn_flg, 1);
        check("exh_busy", busy, 0);
        repeat (3) begin
            adv(); mid();
            check("exh_hold_start", eng_start, 0);
            check("exh_hold_flag", inc_vrn_flg, 1);
        end

        // Deferred ticks land on the next batch only.
        adv(); job_load = 1'b1; job_nonce = 32'h0000_0000; job_time = 32'h0000_0001; mid();
        adv(); mid();
        check("tick_flag_cleared", inc_vrn_flg, 0);
        check("tick_b1_time", hdr_time, 32'h0000_0001);
        adv(); sec_tick = 1'b1; mid();
        adv(); sec_tick = 1'b1; mid();
        check("tick_b1_hold", hdr_time, 32'h0000_0001);
        adv(); eng_done = 3'b111; mid();
        adv(); mid();
        check("tick_b2_start", eng_start, 3'b111);
        check("tick_b2_time", hdr_time, 32'h0200_0001);

        // Enable low freezes the FSM while completions still accumulate.
        adv(); en = 1'b0; eng_done = 3'b111; mid();
        adv(); mid();
        check("en_wait_busy", busy, 1);
        check("en_wait_start", eng_start, 0);
        adv(); en = 1'b1; mid();
        adv(); en = 1'b0; mid();
        check("en_issue_gated", eng_start, 0);
        check("en_issue_busy", busy, 1);
        adv(); en = 1'b1; mid();
        check("en_b3_start", eng_start, 3'b111);
        check("en_b3_nonce", eng_nonce, {32'h0800_0000, 32'h0700_0000, 32'h0600_0000});

        // Asynchronous reset in WAIT, then abandon a batch with a new load.
        adv(); mid();
        #1 rst = 1'b0;
        #1 check_all_zero("arst");
        @(posedge clk);
        #1 rst = 1'b1;
        adv(); job_load = 1'b1; job_nonce = 32'h0000_0100; job_time = 32'hAABB_CCDD; mid();
        adv(); mid();
        check("ab_y_start", eng_start, 3'b111);
        adv(); job_load = 1'b1; job_nonce = 32'h0000_0200; eng_done = 3'b111; mid();
        adv(); eng_done = 3'b111; mid();
        check("ab_z_start", eng_start, 3'b111);
        check("ab_z_nonce", eng_nonce, {32'h0200_0200, 32'h0100_0200, 32'h0000_0200});
        adv(); mid();
        adv(); mid();
        check("ab_stale_busy", busy, 1);
        check("ab_stale_start", eng_start, 0);
        check("ab_stale_vld", found_vld, 0);
        adv(); eng_done = 3'b111; mid();
        adv(); mid();
        check("ab_z2_start", eng_start, 3'b111);
        check("ab_z2_nonce", eng_nonce, {32'h0500_0200, 32'h0400_0200, 32'h0300_0200});

        for (int j = 0; j < 60; j++) random_job();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
